// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: byte-oriented SPI master. Sequences one full transfer per accepted start:
// chip select low, SETUP for one SCK half-period, 2*DW SCK edges, HOLD for one half-period,
// then chip select high with a one-cycle done pulse. SCK only runs while a transfer is active.
//
// Optional feature: define SPI_LSB_FIRST_EN to add the lsb_first input (LSB-first order).
//
// Ports:
//   iclk       system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      transfer request, sampled only in IDLE
//   tx_data    word to send, latched on accept
//   mode       SPI mode {CPOL, CPHA}, latched on accept
//   ps         prescale, SCK half-period = ps+1 iclk cycles, latched on accept
//   lsb_first  (SPI_LSB_FIRST_EN only) 1 = LSB-first, latched on accept
//   miso       serial data in
//   busy       transfer in progress
//   done       one-cycle completion pulse
//   rx_data    last received word
//   sck        SPI clock
//   mosi       serial data out
//   cs_n       active-low chip select
module spi_master_ctrl #(
   parameter int unsigned DW = 8
) (
   input  logic          iclk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] tx_data,
   input  logic [1:0]    mode,
   input  logic [1:0]    ps,
`ifdef SPI_LSB_FIRST_EN
   input  logic          lsb_first,
`endif
   input  logic          miso,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] rx_data,
   output logic          sck,
   output logic          mosi,
   output logic          cs_n
);

   localparam int unsigned EW = $clog2(2 * DW + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    ps_q, ps_d;
   logic [1:0]    hcnt_q, hcnt_d;
   logic [EW-1:0] ecnt_q, ecnt_d;
   logic [DW-1:0] txsr_q, txsr_d;
   logic [DW-1:0] rxsr_q, rxsr_d;
   logic [DW-1:0] rx_q, rx_d;
   logic          lsb_q, lsb_d;
   logic          sck_q, sck_d;
   logic          mosi_q, mosi_d;
   logic          cs_n_q, cs_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          lsb_in;
   logic          hexp;
   logic          lead;
   logic          smp;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   assign hexp = (hcnt_q == 2'd0);
   // Edge counter is even before a leading (odd-numbered) edge.
   assign lead = ~ecnt_q[0];
   // Sample on leading edges for CPHA=0, trailing edges for CPHA=1.
   assign smp  = lead ^ mode_q[0];

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      ps_d    = ps_q;
      hcnt_d  = hcnt_q;
      ecnt_d  = ecnt_q;
      txsr_d  = txsr_q;
      rxsr_d  = rxsr_q;
      rx_d    = rx_q;
      lsb_d   = lsb_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cs_n_d = 1'b1;
            busy_d = 1'b0;
            if (start) begin
               mode_d  = mode;
               ps_d    = ps;
               lsb_d   = lsb_in;
               hcnt_d  = ps;
               ecnt_d  = EW'(2 * DW);
               sck_d   = mode[1];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               rxsr_d  = '0;
               state_d = StSetup;
               // CPHA=0 presents the first bit before the first SCK edge.
               if (!mode[0]) begin
                  mosi_d = lsb_in ? tx_data[0] : tx_data[DW-1];
                  txsr_d = lsb_in ? (tx_data >> 1) : (tx_data << 1);
               end else begin
                  txsr_d = tx_data;
               end
            end
         end
         StSetup: begin
            if (hexp) begin
               hcnt_d  = ps_q;
               state_d = StShift;
            end else begin
               hcnt_d = hcnt_q - 2'd1;
            end
         end
         StShift: begin
            if (hexp) begin
               hcnt_d = ps_q;
               sck_d  = ~sck_q;
               ecnt_d = ecnt_q - EW'(1);
               if (smp) begin
                  rxsr_d = lsb_q ? {miso, rxsr_q[DW-1:1]} : {rxsr_q[DW-2:0], miso};
               end else if (ecnt_q != EW'(1)) begin
                  mosi_d = lsb_q ? txsr_q[0] : txsr_q[DW-1];
                  txsr_d = lsb_q ? (txsr_q >> 1) : (txsr_q << 1);
               end
               if (ecnt_q == EW'(1)) begin
                  state_d = StHold;
               end
            end else begin
               hcnt_d = hcnt_q - 2'd1;
            end
         end
         StHold: begin
            if (hexp) begin
               state_d = StIdle;
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               rx_d    = rxsr_q;
            end else begin
               hcnt_d = hcnt_q - 2'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= 2'd0;
         ps_q    <= 2'd0;
         hcnt_q  <= 2'd0;
         ecnt_q  <= '0;
         txsr_q  <= '0;
         rxsr_q  <= '0;
         rx_q    <= '0;
         lsb_q   <= 1'b0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         ps_q    <= ps_d;
         hcnt_q  <= hcnt_d;
         ecnt_q  <= ecnt_d;
         txsr_q  <= txsr_d;
         rxsr_q  <= rxsr_d;
         rx_q    <= rx_d;
         lsb_q   <= lsb_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign sck     = sck_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule
